com_strip_rx: RTL
=================

Name: com_strip_rx

Overview:
Receive-side counterpart of the transmit COM-insertion stage. It takes the recovered 8-bit symbol stream on cclk and recognises the idle/COM symbol (0xBC). It acquires symbol sync after a run of consecutive COMs, strips COMs from the stream, and regenerates a valid strobe for the data bytes. It sits between the RX deserializer/decoder and the RX link-layer logic, and drops sync after repeated decode errors.

Parameters:
COM_SYMBOL  8'hBC  idle/COM symbol value inserted by TX when no valid data
SYNC_COMS   4      consecutive error-free COMs required to declare sync (>=1)
ERR_LIMIT   3      consecutive errored symbols in SYNCED that force loss of sync (>=1)

Ports:
cclk            input   1  symbol clock; all logic on posedge
default_values  input   1  asynchronous, active-high reset
data_in         input   8  recovered symbol, one per cclk
err_in          input   1  upstream decode/disparity error flag for data_in, same cycle
data_out        output  8  recovered data byte (registered)
valid_out       output  1  data_out carries a new data byte this cycle
active          output  1  receiver is in SYNCED state

Behaviour:
- Reset (default_values=1, asynchronous): state=LOSS_OF_SYNC; com_cnt=0; err_cnt=0; data_out=8'h00; valid_out=0; active=0. Reset asserted mid-stream takes effect immediately, regardless of cclk.
- Symbol classes per edge:
  - ERR: err_in=1 (includes a COM value with err_in=1).
  - COM: data_in==COM_SYMBOL and err_in=0.
  - DATA: any other symbol with err_in=0.
- All outputs are registered. A symbol sampled at edge N appears on data_out/valid_out after edge N (1-cycle latency). Decisions use the state held before edge N.
- LOSS_OF_SYNC:
  - COM → com_cnt=1; go to ACQUIRE, or straight to SYNCED if SYNC_COMS==1.
  - DATA or ERR → stay, com_cnt=0.
  - valid_out=0.
- ACQUIRE:
  - COM → com_cnt+1. When the count reaches SYNC_COMS, go to SYNCED and clear com_cnt.
  - DATA or ERR → LOSS_OF_SYNC, com_cnt=0.
  - valid_out=0.
- SYNCED:
  - DATA → data_out<=data_in, valid_out=1, err_cnt=0.
  - COM → valid_out=0, data_out held, err_cnt=0.
  - ERR → valid_out=0, data_out held, err_cnt+1. When err_cnt reaches ERR_LIMIT, go to LOSS_OF_SYNC and clear err_cnt and com_cnt.
- active = registered (state==SYNCED). It rises on the same edge that samples the SYNC_COMS-th COM, and falls on the edge that samples the ERR_LIMIT-th consecutive ERR.
- data_out changes only on valid DATA bytes. It holds its last value otherwise, including after loss of sync, until reset.
- Bytes equal to COM_SYMBOL are never delivered as data.
- A DATA byte in ACQUIRE or LOSS_OF_SYNC is discarded (valid_out=0).
- Counters are sized $clog2(param)+1 and never wrap; each is cleared on every state exit.

Test Plan:
- Reset, then 4×0xBC, then 0x11,0x22 → active=1 after the 4th COM edge; valid_out=1 with data_out=0x11 and then 0x22 on consecutive cycles.
- 3×0xBC, 0x55, 4×0xBC, 0x66 → 0x55 discarded (valid_out=0, active=0); sync after the second COM run; 0x66 delivered with valid_out=1.
- Synced, stream 0x01,0xBC,0xBC,0x02 → valid_out pattern 1,0,0,1; data_out stays 0x01 through the COMs, then becomes 0x02.
- Synced, 2 ERR, 0x33, 3 ERR → 0x33 delivered and err_cnt cleared; the third ERR drops active to 0; the following 0x44 is not delivered.
- 0xBC with err_in=1 during ACQUIRE → return to LOSS_OF_SYNC; 4 clean COMs are needed again.
- default_values pulsed between cclk edges while synced with valid_out=1 → data_out=0, valid_out=0, active=0 immediately; resync needs 4 COMs.

Source files
------------

// File: rtl/com_strip_rx.sv
`default_nettype none
// ============================================================================
// Module      : com_strip_rx
// Description : RX COM stripper. Acquires symbol sync on a run of COMs, drops
//               COMs from the stream, regenerates a data-valid strobe and
//               loses sync after consecutive decode errors.
// Revision    : 1.0 - initial release
// ============================================================================
module com_strip_rx #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         SYNC_COMS  = 4,
    parameter int         ERR_LIMIT  = 3
) (
    input  logic       cclk,
    input  logic       default_values,
    input  logic [7:0] data_in,
    input  logic       err_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int CW = $clog2(SYNC_COMS) + 1;
    localparam int EW = $clog2(ERR_LIMIT) + 1;
    localparam logic [CW-1:0] c_SYNC_COMS = CW'(SYNC_COMS);
    localparam logic [EW-1:0] c_ERR_LIMIT = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_LOSS    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_SYNCED  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [CW-1:0]   r_com_cnt;
    logic [CW-1:0]   w_com_cnt_n;
    logic [EW-1:0]   r_err_cnt;
    logic [EW-1:0]   w_err_cnt_n;
    logic [7:0]      r_data;
    logic [7:0]      w_data_n;
    logic            r_valid;
    logic            w_valid_n;
    logic            r_active;

    logic            w_is_err;
    logic            w_is_com;
    logic            w_is_data;

    assign w_is_err  = err_in;
    assign w_is_com  = !err_in && (data_in == COM_SYMBOL);
    assign w_is_data = !err_in && (data_in != COM_SYMBOL);

    always_ff @(posedge cclk or posedge default_values) begin
        if (default_values) begin
            r_state   <= ST_LOSS;
            r_com_cnt <= '0;
            r_err_cnt <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_com_cnt <= w_com_cnt_n;
            r_err_cnt <= w_err_cnt_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_active  <= (w_state_n == ST_SYNCED);
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_com_cnt_n = r_com_cnt;
        w_err_cnt_n = r_err_cnt;
        w_data_n    = r_data;
        w_valid_n   = 1'b0;

        case (r_state)
            ST_LOSS: begin
                if (w_is_com) begin
                    // A single-COM sync requirement skips ACQUIRE entirely
                    if (c_SYNC_COMS == CW'(1)) begin
                        w_state_n   = ST_SYNCED;
                        w_com_cnt_n = '0;
                    end else begin
                        w_state_n   = ST_ACQUIRE;
                        w_com_cnt_n = CW'(1);
                    end
                end else begin
                    w_com_cnt_n = '0;
                end
            end

            ST_ACQUIRE: begin
                if (w_is_com) begin
                    if (r_com_cnt + CW'(1) == c_SYNC_COMS) begin
                        w_state_n   = ST_SYNCED;
                        w_com_cnt_n = '0;
                    end else begin
                        w_com_cnt_n = r_com_cnt + CW'(1);
                    end
                end else begin
                    w_state_n   = ST_LOSS;
                    w_com_cnt_n = '0;
                end
            end

            ST_SYNCED: begin
                if (w_is_data) begin
                    w_data_n    = data_in;
                    w_valid_n   = 1'b1;
                    w_err_cnt_n = '0;
                end else if (w_is_com) begin
                    w_err_cnt_n = '0;
                end else if (w_is_err) begin
                    if (r_err_cnt + EW'(1) == c_ERR_LIMIT) begin
                        w_state_n   = ST_LOSS;
                        w_err_cnt_n = '0;
                        w_com_cnt_n = '0;
                    end else begin
                        w_err_cnt_n = r_err_cnt + EW'(1);
                    end
                end
            end

            default: begin
                w_state_n   = ST_LOSS;
                w_com_cnt_n = '0;
                w_err_cnt_n = '0;
            end
        endcase
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign active    = r_active;

endmodule
`default_nettype wire
